// File: rtl/hilo_divider.sv
// Unsigned 32-bit restoring divider producing HI (remainder) and LO (quotient) for DIVU.
// One quotient bit per cycle; results commit to HiOut/LoOut only on the DONE edge.
module hilo_divider (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] dataA,
    input  logic [31:0] dataB,
    input  logic [5:0]  Signal,
    output logic [31:0] HiOut,
    output logic [31:0] LoOut,
    output logic        busy,
    output logic        done
);

    // state | meaning
    // IDLE  | waiting for DIVU; HiOut/LoOut hold last result
    // RUN   | 32 shift-subtract steps, one per clock
    // DONE  | result ready; committed to HiOut/LoOut on the next edge
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [5:0] DIVU = 6'b011011;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_dq;
    logic [31:0] r_divisor;
    logic [32:0] r_rem;
    logic [4:0]  r_count;

    logic        w_start;
    logic [32:0] w_rem33;
    logic [32:0] w_diff;
    logic        w_ge;

    assign w_start = (r_state == S_IDLE) && (Signal == DIVU);
    assign w_rem33 = {r_rem[31:0], r_dq[31]};
    assign w_diff  = w_rem33 - {1'b0, r_divisor};
    assign w_ge    = (w_rem33 >= {1'b0, r_divisor});

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    w_state_nxt = (dataB == 32'd0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                busy = 1'b1;
                if (r_count == 5'd31) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                busy        = 1'b1;
                done        = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // r_dq holds the dividend; quotient bits shift in at the LSB as dividend bits leave the MSB.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_dq      <= 32'd0;
            r_divisor <= 32'd0;
            r_rem     <= 33'd0;
            r_count   <= 5'd0;
            HiOut     <= 32'd0;
            LoOut     <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_count <= 5'd0;
                        if (dataB == 32'd0) begin
                            r_dq  <= 32'hFFFF_FFFF;
                            r_rem <= {1'b0, dataA};
                        end else begin
                            r_dq      <= dataA;
                            r_divisor <= dataB;
                            r_rem     <= 33'd0;
                        end
                    end
                end
                S_RUN: begin
                    r_rem   <= w_ge ? w_diff : w_rem33;
                    r_dq    <= {r_dq[30:0], w_ge};
                    r_count <= r_count + 5'd1;
                end
                S_DONE: begin
                    HiOut <= r_rem[31:0];
                    LoOut <= r_dq;
                end
                default: begin
                    r_count <= 5'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hilo_divider.sv
// Scoreboard bench for hilo_divider: stimulus pushes expected {HI,LO}; a monitor
// pops and compares after every DONE commit edge.
module tb_hilo_divider;

    localparam logic [5:0] DIVU = 6'b011011;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] dataA;
    logic [31:0] dataB;
    logic [5:0]  Signal;
    logic [31:0] HiOut;
    logic [31:0] LoOut;
    logic        busy;
    logic        done;

    hilo_divider dut (
        .clk    (clk),
        .reset  (reset),
        .dataA  (dataA),
        .dataB  (dataB),
        .Signal (Signal),
        .HiOut  (HiOut),
        .LoOut  (LoOut),
        .busy   (busy),
        .done   (done)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          done_pulses = 0;
    logic [63:0] exp_q[$];
    logic [63:0] exp_e;
    logic [31:0] mdl_hi = 32'd0;
    logic [31:0] mdl_lo = 32'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // monitor: done seen mid-cycle, result must appear after the following edge
    always @(negedge clk) begin
        if (done === 1'b1) begin
            done_pulses++;
            @(posedge clk);
            #1;
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL sb_unexpected_done: got done with empty queue, expected none");
            end else begin
                exp_e = exp_q.pop_front();
                check("sb_hi", HiOut, exp_e[63:32]);
                check("sb_lo", LoOut, exp_e[31:0]);
            end
        end
    end

    // start a divide, optionally inject a second DIVU while busy, count busy cycles
    task automatic run_div(input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] eh, input logic [31:0] el,
                           input int exp_cycles, input int intf_cycle);
        int cyc;
        int pulses0;
        @(negedge clk);
        pulses0 = done_pulses;
        exp_q.push_back({eh, el});
        Signal = DIVU;
        dataA  = a;
        dataB  = b;
        @(posedge clk);
        #1;
        Signal = 6'd0;
        dataA  = $urandom;
        dataB  = $urandom;
        cyc    = 0;
        while (busy === 1'b1 && cyc < 100) begin
            check("hold_hi", HiOut, mdl_hi);
            check("hold_lo", LoOut, mdl_lo);
            cyc++;
            if (cyc == intf_cycle) begin
                Signal = DIVU;
                dataA  = 32'd9;
                dataB  = 32'd3;
            end else begin
                Signal = 6'd0;
            end
            @(posedge clk);
            #1;
        end
        Signal = 6'd0;
        check("busy_cycles", 32'(cyc), 32'(exp_cycles));
        check("done_pulses", 32'(done_pulses - pulses0), 32'd1);
        mdl_hi = eh;
        mdl_lo = el;
    endtask

    initial begin
        reset  = 1'b1;
        Signal = 6'd0;
        dataA  = 32'd0;
        dataB  = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_hi", HiOut, 32'd0);
        check("rst_lo", LoOut, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);

        // reset wins over a simultaneous DIVU
        Signal = DIVU;
        dataA  = 32'd3;
        dataB  = 32'd1;
        @(posedge clk);
        #1;
        check("rst_prio_busy", {31'd0, busy}, 32'd0);
        Signal = 6'd0;
        reset  = 1'b0;

        run_div(32'd100, 32'd7, 32'd2, 32'd14, 33, -1);
        run_div(32'hFFFF_FFFF, 32'd1, 32'd0, 32'hFFFF_FFFF, 33, -1);
        run_div(32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'd1, 33, -1);
        run_div(32'd7, 32'd100, 32'd7, 32'd0, 33, -1);
        run_div(32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 1, -1);
        run_div(32'd100, 32'd7, 32'd2, 32'd14, 33, 5);

        // non-DIVU codes must be inert
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            Signal = (i == 0) ? 6'b011010 : ((i == 1) ? 6'b011001 : ((i == 2) ? 6'b111011 : 6'b000000));
            dataA  = 32'd40;
            dataB  = 32'd4;
            @(posedge clk);
            #1;
            check("nop_busy", {31'd0, busy}, 32'd0);
            check("nop_lo", LoOut, mdl_lo);
        end
        Signal = 6'd0;

        // abort mid-RUN with reset: outputs must clear, no partial result
        @(negedge clk);
        Signal = DIVU;
        dataA  = 32'd50;
        dataB  = 32'd5;
        @(posedge clk);
        #1;
        Signal = 6'd0;
        repeat (10) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("abort_hi", HiOut, 32'd0);
        check("abort_lo", LoOut, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        mdl_hi = 32'd0;
        mdl_lo = 32'd0;

        run_div(32'd50, 32'd5, 32'd0, 32'd10, 33, -1);

        repeat (3) @(posedge clk);
        #1;
        check("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/hilo_divider.md
HILO_DIVIDER -- requirements
Module: hilo_divider

Interface
REQ-001 The block SHALL have exactly one clock and SHALL use a synchronous, active-high reset.
REQ-002 Port clk, input, 1 bit: the single clock; all state updates SHALL occur on its rising edge.
REQ-003 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 Port dataA, input, 32 bits: dividend (rs operand), unsigned.
REQ-005 Port dataB, input, 32 bits: divisor (rt operand), unsigned.
REQ-006 Port Signal, input, 6 bits: funct code; 6'b011011 (DIVU) requests a divide, and all other codes are no-ops for this block.
REQ-007 Port HiOut, output, 32 bits: HI register (remainder); it feeds the ALU result mux MFHI path.
REQ-008 Port LoOut, output, 32 bits: LO register (quotient); it feeds the ALU result mux MFLO path.
REQ-009 Port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-010 Port done, output, 1 bit: one-cycle pulse, high only in state DONE.

Function
REQ-011 The block SHALL have three states: IDLE, RUN and DONE.
REQ-012 IDLE, Signal==DIVU, dataB!=0 at a rising edge: latch dataA and dataB; set remainder accumulator to 0 and step count to 0; go to RUN.
REQ-013 IDLE, Signal==DIVU, dataB==0 at a rising edge: set quotient to 32'hFFFFFFFF and remainder to dataA; go directly to DONE.
REQ-014 RUN, each edge, one restoring shift-subtract step:
  - rem33 = {rem[31:0], dividend MSB}, with the dividend shifted left by 1;
  - if rem33 >= {1'b0, divisor}: rem = rem33 - divisor and quotient LSB = 1;
  - otherwise: rem = rem33 and quotient LSB = 0.
REQ-015 The remainder datapath SHALL be 33 bits wide so that an intermediate 32-bit overflow is never lost; HiOut takes the low 32 bits.
REQ-016 RUN SHALL go to DONE on the edge that performs step 32 (count==31); count SHALL NOT wrap into a 33rd step.
REQ-017 DONE: on the next edge, HiOut <= remainder and LoOut <= quotient; go to IDLE.
REQ-018 Latency, normal divide:
  - start edge E0;
  - RUN steps on E1..E32;
  - new HiOut/LoOut visible after E33;
  - busy high for 33 cycles; done high for the single cycle between E32 and E33.
REQ-019 Latency, divide by zero: DONE is entered after E0, results are visible after E1, and busy/done are high for 1 cycle.
REQ-020 HiOut and LoOut SHALL hold their previous values at all times until the DONE commit edge; MFHI/MFLO reads during busy return the old values.
REQ-021 A DIVU request while busy SHALL be ignored: no restart and no queueing; the operand latches are unchanged.
REQ-022 dataA and dataB changes after the start edge SHALL NOT affect the result in progress.
REQ-023 Non-DIVU Signal codes SHALL never alter state, HiOut or LoOut.
REQ-024 In IDLE with Signal==DIVU held for consecutive cycles, a new divide SHALL start on the first edge where the state is IDLE, including the edge immediately after the DONE commit.

Reset
REQ-025 When reset is high at a rising edge, the block SHALL set: state=IDLE, HiOut=0, LoOut=0, busy=0, done=0, count=0, and internal accumulators=0.
REQ-026 Reset SHALL take priority over any DIVU request on the same edge.
REQ-027 Reset mid-operation (RUN or DONE) SHALL abort the divide, and no partial result SHALL reach HiOut or LoOut.

Verification
REQ-028 Reset, then DIVU with dataA=100 and dataB=7 -> busy for 33 cycles; then LoOut=14 and HiOut=2, with done pulsing exactly once.
REQ-029 DIVU with dataA=32'hFFFFFFFF and dataB=1 -> LoOut=32'hFFFFFFFF and HiOut=0; then dataA=32'hFFFFFFFF and dataB=32'h80000000 -> LoOut=1 and HiOut=32'h7FFFFFFF.
REQ-030 DIVU with dataA=5 and dataB=0 -> busy high for 1 cycle; then LoOut=32'hFFFFFFFF and HiOut=5.
REQ-031 DIVU with 100/7 started, then DIVU with 9/3 issued at cycle 5 with dataA/dataB changed -> the second request is ignored; final values are LoOut=14 and HiOut=2.
REQ-032 Prior result LoOut=14, new DIVU 50/5, reset asserted at RUN step 10 -> next cycle: HiOut=0, LoOut=0, busy=0; a following DIVU 50/5 gives LoOut=10 and HiOut=0.
REQ-033 During a running divide, check every cycle -> HiOut and LoOut equal their pre-start values until the commit edge.
